// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_arbiter
// Purpose  : Round-robin arbiter that funnels NREQ read/write requesters onto
//            a single memory port. It keeps one access outstanding at a time.
//            The grant is a one-cycle pulse in the first BUSY cycle. The
//            completion pulse (with read data) follows ram_done by one cycle.
// Params   : NREQ   - number of requesters (2..8)
//            WORD_W - address / data width
// Ports    : CLK, RST              - clock, synchronous active-high reset
//            req_ren/req_wen       - per-requester read / write request
//            req_addr/req_store    - per-requester address / write data,
//                                    requester i at [i*WORD_W +: WORD_W]
//            req_gnt/req_done      - one-hot grant / completion pulses
//            req_load              - read data, valid with req_done
//            ramREN/ramWEN         - memory strobes, held until ram_done
//            ramaddr/ramstore      - memory address / write data
//            ramload/ram_done      - memory read data / completion pulse
//            busy                  - an access is outstanding
// Options  : MEM_REQ_ARBITER_WRITE_PRIO_EN - while any write is pending, only
//            writers take part in the round-robin search.
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_arbiter #(
    parameter int NREQ   = 4,
    parameter int WORD_W = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NREQ-1:0]        req_ren,
    input  logic [NREQ-1:0]        req_wen,
    input  logic [NREQ*WORD_W-1:0] req_addr,
    input  logic [NREQ*WORD_W-1:0] req_store,
    output logic [NREQ-1:0]        req_gnt,
    output logic [NREQ-1:0]        req_done,
    output logic [WORD_W-1:0]      req_load,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [WORD_W-1:0]      ramaddr,
    output logic [WORD_W-1:0]      ramstore,
    input  logic [WORD_W-1:0]      ramload,
    input  logic                   ram_done,
    output logic                   busy
);

    localparam int             c_PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [0:0]     c_IDLE = 1'b0;
    localparam logic [0:0]     c_BUSY = 1'b1;
    localparam logic [NREQ-1:0] c_ONE = {{(NREQ-1){1'b0}}, 1'b1};

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [c_PW-1:0]   r_rr_ptr;
    logic [c_PW-1:0]   r_owner;
    logic [c_PW-1:0]   w_win;
    logic [c_PW-1:0]   w_idx;
    logic              w_found;
    logic [NREQ-1:0]   w_pend;
    logic [NREQ-1:0]   w_elig;
    logic [WORD_W-1:0] w_sel_addr;
    logic [WORD_W-1:0] w_sel_store;
    logic              w_sel_wr;
    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] r_store;
    logic [WORD_W-1:0] r_load;
    logic              r_is_wr;
    logic              r_first;
    logic [NREQ-1:0]   r_done;
    logic [NREQ-1:0]   w_owner_oh;
    logic              w_start;
    logic              w_finish;

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------
    assign w_pend = req_ren | req_wen;

`ifdef MEM_REQ_ARBITER_WRITE_PRIO_EN
    // Pending writers shadow all readers until none is left.
    assign w_elig = (|req_wen) ? req_wen : w_pend;
`else
    assign w_elig = w_pend;
`endif

    // First eligible requester at or above the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = c_PW'((int'(r_rr_ptr) + k) % NREQ);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Mux out the winner's address, data and access type. A simultaneous
    // read and write request counts as a write.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_store = '0;
        w_sel_wr    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == c_PW'(i)) begin
                w_sel_addr  = req_addr[i*WORD_W +: WORD_W];
                w_sel_store = req_store[i*WORD_W +: WORD_W];
                w_sel_wr    = req_wen[i];
            end
        end
    end

    assign w_start    = (r_state == c_IDLE) && w_found;
    assign w_finish   = (r_state == c_BUSY) && ram_done;
    assign w_owner_oh = c_ONE << r_owner;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. ram_done outside BUSY is ignored.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_found)  w_state_nxt = c_BUSY;
            c_BUSY:  if (ram_done) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. The memory side is gated by busy so it reads zero
    // whenever no access is outstanding.
    // ------------------------------------------------------------------
    always_comb begin
        busy     = (r_state == c_BUSY);
        req_gnt  = (busy && r_first) ? w_owner_oh : '0;
        req_done = r_done;
        req_load = r_load;
        ramREN   = busy && !r_is_wr;
        ramWEN   = busy && r_is_wr;
        ramaddr  = busy ? r_addr  : '0;
        ramstore = busy ? r_store : '0;
    end

    // ------------------------------------------------------------------
    // Access registers, completion pulse and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_addr   <= '0;
            r_store  <= '0;
            r_is_wr  <= 1'b0;
            r_first  <= 1'b0;
            r_done   <= '0;
            r_load   <= '0;
        end else begin
            r_first <= w_start;
            r_done  <= '0;
            r_load  <= '0;
            if (w_start) begin
                r_owner <= w_win;
                r_addr  <= w_sel_addr;
                r_store <= w_sel_wr ? w_sel_store : '0;
                r_is_wr <= w_sel_wr;
            end
            if (w_finish) begin
                r_done   <= w_owner_oh;
                r_load   <= r_is_wr ? '0 : ramload;
                r_rr_ptr <= (r_owner == c_PW'(NREQ-1)) ? '0 : r_owner + c_PW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_req_arbiter
// Purpose  : Directed self-checking bench for mem_req_arbiter (NREQ=4,
//            WORD_W=32). Inputs change and outputs are sampled on the falling
//            clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_req_arbiter;

    localparam int NREQ   = 4;
    localparam int WORD_W = 32;

    logic                   CLK;
    logic                   RST;
    logic [NREQ-1:0]        req_ren;
    logic [NREQ-1:0]        req_wen;
    logic [NREQ*WORD_W-1:0] req_addr;
    logic [NREQ*WORD_W-1:0] req_store;
    logic [NREQ-1:0]        req_gnt;
    logic [NREQ-1:0]        req_done;
    logic [WORD_W-1:0]      req_load;
    logic                   ramREN;
    logic                   ramWEN;
    logic [WORD_W-1:0]      ramaddr;
    logic [WORD_W-1:0]      ramstore;
    logic [WORD_W-1:0]      ramload;
    logic                   ram_done;
    logic                   busy;

    int n_checks = 0;
    int n_errors = 0;

    mem_req_arbiter #(.NREQ(NREQ), .WORD_W(WORD_W)) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_ren   (req_ren),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_store (req_store),
        .req_gnt   (req_gnt),
        .req_done  (req_done),
        .req_load  (req_load),
        .ramREN    (ramREN),
        .ramWEN    (ramWEN),
        .ramaddr   (ramaddr),
        .ramstore  (ramstore),
        .ramload   (ramload),
        .ram_done  (ram_done),
        .busy      (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".gnt"},      64'(req_gnt),  64'h0);
        check({tag, ".done"},     64'(req_done), 64'h0);
        check({tag, ".load"},     64'(req_load), 64'h0);
        check({tag, ".ren"},      64'(ramREN),   64'h0);
        check({tag, ".wen"},      64'(ramWEN),   64'h0);
        check({tag, ".addr"},     64'(ramaddr),  64'h0);
        check({tag, ".store"},    64'(ramstore), 64'h0);
        check({tag, ".busy"},     64'(busy),     64'h0);
    endtask

    // Called from the grant cycle: waits one cycle, pulses ram_done, then
    // checks the completion pulse in the following (IDLE) cycle.
    task automatic complete(input string tag, input logic [3:0] exp_done,
                            input logic [31:0] ld, input logic [31:0] exp_load);
        tick();
        ram_done = 1'b1;
        ramload  = ld;
        tick();
        ram_done = 1'b0;
        ramload  = '0;
        check({tag, ".done"},  64'(req_done), 64'(exp_done));
        check({tag, ".load"},  64'(req_load), 64'(exp_load));
        check({tag, ".busy"},  64'(busy),     64'h0);
        check({tag, ".strb"},  64'({ramREN, ramWEN}), 64'h0);
    endtask

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] e;

        RST       = 1'b1;
        req_ren   = '0;
        req_wen   = '0;
        req_addr  = '0;
        req_store = '0;
        ramload   = '0;
        ram_done  = 1'b0;

        // Reset state
        tick();
        check_all_zero("reset");
        tick();
        RST = 1'b0;

        // Single read on requester 1
        req_ren = 4'b0010;
        req_addr[1*WORD_W +: WORD_W] = 32'h100;
        tick();
        check("rd.gnt",   64'(req_gnt),  64'h2);
        check("rd.ren",   64'(ramREN),   64'h1);
        check("rd.wen",   64'(ramWEN),   64'h0);
        check("rd.addr",  64'(ramaddr),  64'h100);
        check("rd.store", 64'(ramstore), 64'h0);
        check("rd.busy",  64'(busy),     64'h1);
        req_ren = '0;
        tick();
        check("rd.gnt_once", 64'(req_gnt), 64'h0);
        check("rd.hold_ren", 64'(ramREN),  64'h1);
        ram_done = 1'b1;
        ramload  = 32'hDEAD;
        tick();
        ram_done = 1'b0;
        ramload  = '0;
        check("rd.done", 64'(req_done), 64'h2);
        check("rd.load", 64'(req_load), 64'hDEAD);
        check("rd.idle", 64'(busy),     64'h0);
        tick();
        check("rd.done_once", 64'(req_done), 64'h0);

        // Spurious completion while idle
        ram_done = 1'b1;
        ramload  = 32'h1234;
        tick();
        ram_done = 1'b0;
        ramload  = '0;
        check("spur.done", 64'(req_done), 64'h0);
        check("spur.load", 64'(req_load), 64'h0);
        check("spur.busy", 64'(busy),     64'h0);
        tick();
        check("spur.busy2", 64'(busy), 64'h0);

        // Write with both REN and WEN on requester 2
        req_ren = 4'b0100;
        req_wen = 4'b0100;
        req_addr[2*WORD_W +: WORD_W]  = 32'h200;
        req_store[2*WORD_W +: WORD_W] = 32'h55;
        tick();
        check("wr.gnt",   64'(req_gnt),  64'h4);
        check("wr.wen",   64'(ramWEN),   64'h1);
        check("wr.ren",   64'(ramREN),   64'h0);
        check("wr.addr",  64'(ramaddr),  64'h200);
        check("wr.store", 64'(ramstore), 64'h55);
        req_ren = '0;
        req_wen = '0;
        complete("wr", 4'b0100, 32'hBEEF, 32'h0);

        // Round-robin, all four reading continuously from reset
        RST = 1'b1;
        tick();
        RST = 1'b0;
        req_ren = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            e = 4'b0001 << order[n];
            tick();
            check("rr.gnt", 64'(req_gnt), 64'(e));
            complete("rr", e, 32'h1000 + 32'(n), 32'h1000 + 32'(n));
        end
        req_ren = '0;

        // Reset in the middle of a read
        req_ren = 4'b0100;
        req_addr[2*WORD_W +: WORD_W] = 32'h300;
        tick();
        check("rst.gnt", 64'(req_gnt), 64'h4);
        check("rst.ren", 64'(ramREN),  64'h1);
        RST     = 1'b1;
        req_ren = 4'b0101;
        tick();
        check_all_zero("rst.mid");
        RST = 1'b0;
        tick();
        check("rst.regnt", 64'(req_gnt),  64'h1);
        check("rst.nodone", 64'(req_done), 64'h0);
        req_ren = '0;
        complete("rst", 4'b0001, 32'hA5A5, 32'hA5A5);

        // Read on 0 vs write on 3, both pending from reset
        RST = 1'b1;
        tick();
        RST = 1'b0;
        req_ren = 4'b0001;
        req_wen = 4'b1000;
        req_addr[3*WORD_W +: WORD_W]  = 32'h400;
        req_store[3*WORD_W +: WORD_W] = 32'h77;
        tick();
`ifdef MEM_REQ_ARBITER_WRITE_PRIO_EN
        check("prio.gnt1", 64'(req_gnt), 64'h8);
        check("prio.wen1", 64'(ramWEN),  64'h1);
        req_wen = '0;
        complete("prio1", 4'b1000, 32'h0, 32'h0);
        tick();
        check("prio.gnt2", 64'(req_gnt), 64'h1);
        req_ren = '0;
        // Requester 1 raises and drops its request while BUSY
        req_ren = 4'b0010;
        tick();
        req_ren = '0;
        ram_done = 1'b1;
        ramload  = 32'h99;
        tick();
        ram_done = 1'b0;
        check("prio2.done", 64'(req_done), 64'h1);
        check("prio2.load", 64'(req_load), 64'h99);
`else
        check("prio.gnt1", 64'(req_gnt), 64'h1);
        check("prio.ren1", 64'(ramREN),  64'h1);
        req_ren = '0;
        complete("prio1", 4'b0001, 32'h66, 32'h66);
        tick();
        check("prio.gnt2", 64'(req_gnt),  64'h8);
        check("prio.st2",  64'(ramstore), 64'h77);
        req_wen = '0;
        // Requester 1 raises and drops its request while BUSY
        req_ren = 4'b0010;
        tick();
        req_ren = '0;
        ram_done = 1'b1;
        ramload  = 32'h99;
        tick();
        ram_done = 1'b0;
        check("prio2.done", 64'(req_done), 64'h8);
        check("prio2.load", 64'(req_load), 64'h0);
`endif
        ramload = '0;
        tick();
        check("drop.gnt",  64'(req_gnt), 64'h0);
        check("drop.busy", 64'(busy),    64'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning the number of requesters, legal range 2..8.
REQ-002 SHALL have parameter WORD_W, default 32, meaning the address and data width.
REQ-003 SHALL have port CLK, input, width 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, width 1, meaning the synchronous, active-high reset.
REQ-005 SHALL have port req_ren, input, width NREQ, meaning the per-requester read request.
REQ-006 SHALL have port req_wen, input, width NREQ, meaning the per-requester write request.
REQ-007 SHALL have port req_addr, input, width NREQ*WORD_W, meaning the per-requester address; requester i uses slice [i*WORD_W +: WORD_W].
REQ-008 SHALL have port req_store, input, width NREQ*WORD_W, meaning the per-requester write data, using the same slicing as req_addr.
REQ-009 SHALL have port req_gnt, output, width NREQ, meaning a one-cycle grant pulse, one-hot.
REQ-010 SHALL have port req_done, output, width NREQ, meaning a one-cycle completion pulse, one-hot.
REQ-011 SHALL have port req_load, output, width WORD_W, meaning the read data, valid while req_done is nonzero.
REQ-012 SHALL have ports ramREN and ramWEN, output, width 1 each, meaning the memory-side strobes.
REQ-013 SHALL have ports ramaddr and ramstore, output, width WORD_W each, meaning the memory-side address and write data.
REQ-014 SHALL have port ramload, input, width WORD_W, meaning the memory read data, valid with ram_done.
REQ-015 SHALL have port ram_done, input, width 1, meaning the memory completion pulse for the outstanding access.
REQ-016 SHALL have port busy, output, width 1, meaning an access is outstanding.

Function
REQ-017 SHALL implement an FSM with two states: IDLE and BUSY.
REQ-018 SHALL, in IDLE, treat requester i as pending when req_ren[i] or req_wen[i] is high.
REQ-019 SHALL select the winner as the first pending requester at or after rr_ptr, searching upward and wrapping modulo NREQ.
REQ-020 SHALL, on the IDLE cycle a winner exists, register the owner index, address, store data and access type, then enter BUSY.
REQ-021 SHALL, in the first BUSY cycle, pulse req_gnt[owner] for exactly one cycle; the grant therefore comes one cycle after the request is sampled.
REQ-022 SHALL, throughout BUSY, drive ramREN or ramWEN (exactly one), ramaddr and ramstore from the registered values; the strobe stays high until ram_done.
REQ-023 SHALL, when both req_ren[i] and req_wen[i] are set, treat the request as a write.
REQ-024 SHALL drive ramstore to 0 for reads.
REQ-025 SHALL handle ram_done sampled high in BUSY in cycle k as follows: in cycle k+1, pulse req_done[owner]; for reads, req_load = ramload captured at k (0 for writes); drop the strobes; return to IDLE; set rr_ptr = (owner+1) mod NREQ.
REQ-026 SHALL allow re-arbitration in the same cycle as req_done, so back-to-back grants are spaced at least 2 cycles apart.
REQ-027 SHALL ignore ram_done while in IDLE, with no state change and no pulse.
REQ-028 SHALL keep at most one access outstanding; requests arriving during BUSY wait and are not queued internally.
REQ-029 SHALL NOT grant a requester that deasserts its request before being selected.
REQ-030 SHALL assert busy exactly while the state is BUSY.

Reset
REQ-031 SHALL, on any cycle RST is sampled high (including mid-BUSY), set the state to IDLE, rr_ptr to 0, and the outstanding access to aborted with no req_done.
REQ-032 SHALL hold all outputs (req_gnt, req_done, req_load, ramREN, ramWEN, ramaddr, ramstore, busy) at 0 from the first edge with RST high until the first edge with RST low.

Configuration
REQ-033 SHALL, when macro MEM_REQ_ARBITER_WRITE_PRIO_EN is defined, restrict the round-robin search to requesters with req_wen set whenever any pending requester has req_wen set; reads are served only when no write is pending.
REQ-034 SHALL, without MEM_REQ_ARBITER_WRITE_PRIO_EN, treat reads and writes equally under pure round-robin.

Verification
REQ-035 SHALL cover single read: req_ren=4'b0010, addr1=0x100 -> cycle+1: req_gnt=4'b0010, ramREN=1, ramaddr=0x100; ram_done with ramload=0xDEAD -> next cycle req_done=4'b0010, req_load=0xDEAD.
REQ-036 SHALL cover round-robin: all four requesters reading continuously from reset -> grant order 0,1,2,3,0 with ram_done 1 cycle after each grant.
REQ-037 SHALL cover a write with simultaneous REN/WEN: req_ren[2]=req_wen[2]=1, store=0x55 -> ramWEN=1, ramREN=0, ramstore=0x55.
REQ-038 SHALL cover reset mid-BUSY: RST high for 1 cycle while ramREN=1 -> next cycle all outputs 0, no req_done, the next grant goes to requester 0 if pending.
REQ-039 SHALL cover write priority: read on requester 0 and write on requester 3 pending from reset -> with MEM_REQ_ARBITER_WRITE_PRIO_EN requester 3 is granted first; without it requester 0 is granted first.
REQ-040 SHALL cover a spurious completion: ram_done pulsed in IDLE -> no req_done, state remains IDLE.
